// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state encoding and select constants for the two-way arbiter
package mux2_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/mux2.sv
// mux2: two-input payload multiplexer, sel = SEL_A picks a
module mux2
   import mux2_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   // purely combinational steering
   always_comb y = (sel == SEL_A) ? a : b;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin packet/burst arbiter for two valid/ready streams sharing one mux2
module mux2_rr_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  a_valid_i,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   input  logic                  a_last_i,
   output logic                  a_ready_o,
   input  logic                  b_valid_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   input  logic                  b_last_i,
   output logic                  b_ready_o,
   output logic                  y_valid_o,
   output logic [DATA_WIDTH-1:0] y_data_o,
   output logic                  y_last_o,
   input  logic                  y_ready_i,
   output logic                  sel_o,
   output logic                  busy_o
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LIM = CW'(MAX_BURST - 1);
   state_t        state, state_n;
   logic          last_grant, last_grant_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          sel_n, beat, rel, oth_valid;
   mux2 #(.WIDTH(DATA_WIDTH + 1)) u_mux (
      .sel (sel_o),
      .a   ({a_data_i, a_last_i}),
      .b   ({b_data_i, b_last_i}),
      .y   ({y_data_o, y_last_o})
   );
   // handshake steering toward the granted requester
   always_comb begin
      a_ready_o = (state == GRANT_A) & y_ready_i;
      b_ready_o = (state == GRANT_B) & y_ready_i;
      y_valid_o = (state == GRANT_A) ? a_valid_i : (state == GRANT_B) ? b_valid_i : 1'b0;
      busy_o    = state != IDLE;
      beat      = y_valid_o & y_ready_i;
      rel       = beat & (y_last_o | cnt == LIM);
      oth_valid = (sel_o == SEL_A) ? b_valid_i : a_valid_i;
   end
   // arbitration: tie goes to the requester not served last; a mid-packet release re-grants the same side when the other is idle
   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      cnt_n        = cnt;
      if (state == IDLE) begin
         state_n = (a_valid_i & (~b_valid_i | last_grant == SEL_B)) ? GRANT_A :
                   b_valid_i ? GRANT_B : IDLE;
      end else if (rel) begin
         last_grant_n = sel_o;
         cnt_n        = '0;
         state_n      = oth_valid ? ((sel_o == SEL_A) ? GRANT_B : GRANT_A) :
                        ~y_last_o ? state : IDLE;
      end else if (beat) begin
         cnt_n = cnt + 1'b1;
      end
      sel_n = (state_n == GRANT_A) ? SEL_A : (state_n == GRANT_B) ? SEL_B : sel_o;
   end
   // state, round-robin memory, burst counter and registered select
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= SEL_B;
         cnt        <= '0;
         sel_o      <= SEL_B;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         cnt        <= cnt_n;
         sel_o      <= sel_n;
      end
   end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: randomized and directed checks against a behavioural arbitration model
module tb_mux2_rr_arbiter;
   localparam int DW = 20;
   localparam int MB = 4;
   logic          clk_i = 1'b0, rst_i = 1'b1;
   logic          a_valid_i = 1'b0, a_last_i = 1'b0, b_valid_i = 1'b0, b_last_i = 1'b0, y_ready_i = 1'b0;
   logic [DW-1:0] a_data_i = '0, b_data_i = '0;
   logic          a_ready_o, b_ready_o, y_valid_o, y_last_o, sel_o, busy_o;
   logic [DW-1:0] y_data_o;
   int nchk = 0, nerr = 0;
   int own = -1, beats = 0, lastw = 1, msel = 0;
   int a_rem = 0, b_rem = 0;
   logic [DW-1:0] a_cnt = 20'd11, b_cnt = 20'h80000;
   logic a_acc, b_acc;

   mux2_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_last_i(a_last_i), .a_ready_o(a_ready_o),
      .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_last_i(b_last_i), .b_ready_o(b_ready_o),
      .y_valid_o(y_valid_o), .y_data_o(y_data_o), .y_last_o(y_last_o), .y_ready_i(y_ready_i),
      .sel_o(sel_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: compare against the model, then advance the model over the edge
   task automatic cyc();
      int on, bn, lw;
      logic ev, el;
      logic [DW-1:0] ed;
      #1;
      if (rst_i) begin own = -1; beats = 0; lastw = 1; msel = 0; end
      ev = own == 0 ? a_valid_i : own == 1 ? b_valid_i : 1'b0;
      ed = msel == 1 ? a_data_i : b_data_i;
      el = msel == 1 ? a_last_i : b_last_i;
      chk("y_valid", {31'd0, y_valid_o}, {31'd0, ev});
      chk("y_data", {12'd0, y_data_o}, {12'd0, ed});
      chk("y_last", {31'd0, y_last_o}, {31'd0, el});
      chk("a_ready", {31'd0, a_ready_o}, (own == 0 && y_ready_i) ? 1 : 0);
      chk("b_ready", {31'd0, b_ready_o}, (own == 1 && y_ready_i) ? 1 : 0);
      chk("sel", {31'd0, sel_o}, msel);
      chk("busy", {31'd0, busy_o}, own >= 0 ? 1 : 0);
      a_acc = own == 0 && a_valid_i && y_ready_i && !rst_i;
      b_acc = own == 1 && b_valid_i && y_ready_i && !rst_i;
      on = own; bn = beats; lw = lastw;
      if (own < 0) begin
         if (a_valid_i && (!b_valid_i || lastw == 1)) on = 0;
         else if (b_valid_i) on = 1;
      end else if (ev && y_ready_i) begin
         bn = beats + 1;
         if (el || bn == MB) begin
            lw = own; bn = 0;
            if (own == 0 ? b_valid_i : a_valid_i) on = 1 - own;
            else on = el ? -1 : own;
         end
      end
      if (rst_i) begin on = -1; bn = 0; lw = 1; end
      @(posedge clk_i);
      msel = on == 0 ? 1 : on == 1 ? 0 : (rst_i ? 0 : msel);
      own = on; beats = bn; lastw = lw;
      @(negedge clk_i);
   endtask

   // drive both sources (percent valid / ready, optional refill up to given packet length), run one cycle
   task automatic gen(int pa, int pb, int py, int ra, int rb);
      if (a_rem == 0 && ra > 0) a_rem = $urandom_range(1, ra);
      if (b_rem == 0 && rb > 0) b_rem = $urandom_range(1, rb);
      a_valid_i = a_rem > 0 && $urandom_range(1, 100) <= pa;
      b_valid_i = b_rem > 0 && $urandom_range(1, 100) <= pb;
      a_data_i = a_cnt; a_last_i = a_rem == 1;
      b_data_i = b_cnt; b_last_i = b_rem == 1;
      y_ready_i = $urandom_range(1, 100) <= py;
      cyc();
      if (a_acc) begin a_cnt++; a_rem--; end
      if (b_acc) begin b_cnt++; b_rem--; end
   endtask

   initial begin
      @(negedge clk_i);
      repeat (2) cyc();
      rst_i = 1'b0;
      repeat (5) gen(0, 0, 100, 0, 0);
      chk("idle_busy", {31'd0, busy_o}, 0);
      a_rem = 3;
      repeat (6) gen(100, 0, 100, 0, 0);
      chk("pkt_done_busy", {31'd0, busy_o}, 0);
      chk("pkt_next_data", {12'd0, a_data_i}, 14);
      repeat (10) gen(100, 100, 100, 1, 1);
      a_rem = 6; b_rem = 0;
      repeat (14) gen(100, 100, 100, 0, 1);
      repeat (3) gen(0, 100, 100, 0, 0);
      a_rem = 0; b_rem = 5;
      repeat (2) gen(100, 100, 100, 0, 0);
      a_rem = 2;
      repeat (4) gen(100, 100, 0, 0, 0);
      chk("hold_sel", {31'd0, sel_o}, 0);
      chk("hold_a_ready", {31'd0, a_ready_o}, 0);
      repeat (10) gen(100, 100, 100, 0, 0);
      a_rem = 5; b_rem = 0;
      repeat (3) gen(100, 0, 100, 0, 0);
      rst_i = 1'b1;
      #1;
      chk("rst_valid", {31'd0, y_valid_o}, 0);
      chk("rst_busy", {31'd0, busy_o}, 0);
      chk("rst_sel", {31'd0, sel_o}, 0);
      chk("rst_a_ready", {31'd0, a_ready_o}, 0);
      @(negedge clk_i);
      cyc();
      rst_i = 1'b0;
      b_rem = 2;
      gen(100, 100, 100, 0, 0);
      chk("tie_sel", {31'd0, sel_o}, 1);
      repeat (2000) gen(70, 70, 75, 6, 6);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
